edge_trig_alu: RTL and testbench

Parametrised, pipelined successor of the single-lane edge-triggered compare-and-add/sub block. Processes NLANES independent NBITS-wide operand pairs per beat and supports four selectable operations. It uses a 2-stage registered pipeline with valid/ready flow control and a beat counter. It sits between operand producers and result consumers in streaming datapaths where backpressure is required.

---
 rtl/edge_trig_pkg.sv | 20 ++
 rtl/edge_trig_lane.sv | 50 +++++
 rtl/edge_trig_alu.sv | 131 +++++++++++++
 tb/tb_edge_trig_alu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_trig_pkg.sv
// Shared types and lane-slicing helpers for the edge-triggered multi-lane ALU.
package edge_trig_pkg;

  typedef enum logic [1:0] {
    CSEL  = 2'd0,
    ADD   = 2'd1,
    SUB   = 2'd2,
    ADIFF = 2'd3
  } alu_mode_t;

  localparam int DEF_NBITS  = 8;
  localparam int DEF_NLANES = 4;
  localparam int DEF_NCOUNT = 16;

  // Lane i occupies [lane_lo(i) +: nbits] of every packed lane bus.
  function automatic int lane_lo(input int lane, input int nbits);
    return lane * nbits;
  endfunction

endpackage

// File: rtl/edge_trig_lane.sv
// One combinational ALU lane: compare-select add/sub, add, sub and absolute difference.
// Define EDGE_TRIG_ALU_SATURATE_EN to clamp add overflow to all-ones and sub underflow to zero.
module edge_trig_lane
  import edge_trig_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic             a_gt_b,
  input  alu_mode_t        mode,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic [NBITS-1:0] result
);

`ifdef EDGE_TRIG_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [NBITS:0]   sum;
  logic [NBITS:0]   diff;
  logic [NBITS-1:0] add_res;
  logic [NBITS-1:0] sub_res;
  logic [NBITS-1:0] adiff_res;

  // The extra top bit of sum/diff is the carry/borrow that drives saturation.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    add_res   = sum[NBITS-1:0];
    sub_res   = diff[NBITS-1:0];
    if (SAT && sum[NBITS]) begin
      add_res = '1;
    end
    if (SAT && diff[NBITS]) begin
      sub_res = '0;
    end
    adiff_res = a_gt_b ? diff[NBITS-1:0] : (b - a);
    result    = '0;
    case (mode)
      CSEL:    result = a_gt_b ? add_res : sub_res;
      ADD:     result = add_res;
      SUB:     result = sub_res;
      ADIFF:   result = adiff_res;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/edge_trig_alu.sv
// Two-stage valid/ready pipelined NLANES x NBITS ALU with an accepted-beat counter.
// Optional macro EDGE_TRIG_ALU_SATURATE_EN enables saturating add/sub inside each lane.
module edge_trig_alu
  import edge_trig_pkg::*;
#(
  parameter int NBITS  = DEF_NBITS,
  parameter int NLANES = DEF_NLANES,
  parameter int NCOUNT = DEF_NCOUNT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  input  logic [NLANES*NBITS-1:0] a,
  input  logic [NLANES*NBITS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANES*NBITS-1:0] xout,
  output logic [NLANES-1:0]       gt,
  output logic [NCOUNT-1:0]       out_count
);

  localparam int W = NLANES * NBITS;

  logic              s1_valid_q, s1_valid_d;
  logic [W-1:0]      s1_a_q, s1_a_d;
  logic [W-1:0]      s1_b_q, s1_b_d;
  alu_mode_t         s1_mode_q, s1_mode_d;
  logic [NLANES-1:0] s1_gt_q, s1_gt_d;

  logic              s2_valid_q, s2_valid_d;
  logic [W-1:0]      xout_q, xout_d;
  logic [NLANES-1:0] gt_q, gt_d;
  logic [NCOUNT-1:0] count_q, count_d;

  logic [NLANES-1:0] gt_in;
  logic [W-1:0]      lane_res;
  logic              s1_load;
  logic              s2_load;

  always_comb begin
    gt_in = '0;
    for (int i = 0; i < NLANES; i++) begin
      gt_in[i] = a[lane_lo(i, NBITS) +: NBITS] > b[lane_lo(i, NBITS) +: NBITS];
    end
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    edge_trig_lane #(
      .NBITS(NBITS)
    ) u_lane (
      .a_gt_b(s1_gt_q[i]),
      .mode  (s1_mode_q),
      .a     (s1_a_q[lane_lo(i, NBITS) +: NBITS]),
      .b     (s1_b_q[lane_lo(i, NBITS) +: NBITS]),
      .result(lane_res[lane_lo(i, NBITS) +: NBITS])
    );
  end

  // A stage advances only when the stage after it can take its contents,
  // so in_ready is the stage-1 load enable and depends combinationally on out_ready.
  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s1_load    = !s1_valid_q || s2_load;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_gt_d    = s1_gt_q;
    s2_valid_d = s2_valid_q;
    xout_d     = xout_q;
    gt_d       = gt_q;
    count_d    = count_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = a;
        s1_b_d    = b;
        s1_mode_d = alu_mode_t'(mode);
        s1_gt_d   = gt_in;
      end
    end

    // Results only change when a real beat moves in, keeping xout quiet on bubbles.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        xout_d = lane_res;
        gt_d   = s1_gt_q;
      end
    end

    if (s2_valid_q && out_ready) begin
      count_d = count_q + NCOUNT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= CSEL;
      s1_gt_q    <= '0;
      s2_valid_q <= 1'b0;
      xout_q     <= '0;
      gt_q       <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s1_gt_q    <= s1_gt_d;
      s2_valid_q <= s2_valid_d;
      xout_q     <= xout_d;
      gt_q       <= gt_d;
      count_q    <= count_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign xout      = xout_q;
  assign gt        = gt_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_edge_trig_alu.sv
// Self-checking bench for edge_trig_alu: fixed vector table, scoreboard, and handshake corner cases.
module tb_edge_trig_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] xout;
  logic [3:0]  gt;
  logic [15:0] out_count;

  edge_trig_alu #(
    .NBITS (8),
    .NLANES(4),
    .NCOUNT(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xout     (xout),
    .gt       (gt),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] xout;
    logic [3:0]  gt;
  } vec_t;

  typedef struct {
    logic [31:0] x;
    logic [3:0]  g;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb[$];
  logic [31:0] cur_x;
  logic [3:0]  cur_g;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] laneModel(input logic [1:0] m, input int av, input int bv);
    int s;
    int d;
    int r;
    s = av + bv;
    d = av - bv;
`ifdef EDGE_TRIG_ALU_SATURATE_EN
    if (s > 255) s = 255;
    if (d < 0) d = 0;
`endif
    case (m)
      2'd0:    r = (av > bv) ? s : d;
      2'd1:    r = s;
      2'd2:    r = d;
      default: r = (av > bv) ? av - bv : bv - av;
    endcase
    return 8'(r);
  endfunction

  function automatic logic [35:0] beatModel(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] x;
    logic [3:0]  g;
    for (int l = 0; l < 4; l++) begin
      x[8*l +: 8] = laneModel(m, int'(av[8*l +: 8]), int'(bv[8*l +: 8]));
      g[l]        = av[8*l +: 8] > bv[8*l +: 8];
    end
    return {g, x};
  endfunction

  // Scoreboard: push on accepted input beats, pop and compare on output transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_beat", {28'd0, gt, xout}, 64'hX);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_result", {28'd0, gt, xout}, {28'd0, e.g, e.x});
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{x: cur_x, g: cur_g});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] ex, input logic [3:0] eg);
    bit done;
    done     = 1'b0;
    mode     = m;
    a        = av;
    b        = bv;
    cur_x    = ex;
    cur_g    = eg;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      done = in_ready;
      step();
    end
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic sendRandom(output logic [35:0] expv);
    logic [1:0]  m;
    logic [31:0] av;
    logic [31:0] bv;
    m    = 2'($urandom_range(0, 3));
    av   = $urandom;
    bv   = $urandom;
    expv = beatModel(m, av, bv);
    applyStimulus(m, av, bv, expv[31:0], expv[35:32]);
  endtask

  task automatic drainPipe();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    step();
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic latencyCheck(input vec_t v);
    mode     = v.mode;
    a        = v.a;
    b        = v.b;
    cur_x    = v.xout;
    cur_g    = v.gt;
    in_valid = 1'b1;
    #1;
    checkOutput("lat_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    checkOutput("lat_edge1_valid", 64'(out_valid), 64'd0);
    step();
    checkOutput("lat_edge2_valid", 64'(out_valid), 64'd1);
    checkOutput("lat_data", {28'd0, gt, xout}, {28'd0, v.gt, v.xout});
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    sb.delete();
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [35:0] e1, e2, e3, r;
    logic [35:0] held;
    int          vcount;
    bit          seen;

    vecs[0] = '{mode: 2'd0, a: {8'd0, 8'd0, 8'd10, 8'd200}, b: {8'd0, 8'd0, 8'd20, 8'd100},
                xout: 32'd0, gt: 4'b0001};
    vecs[1] = '{mode: 2'd3, a: {4{8'd10}}, b: {4{8'd20}}, xout: {4{8'd10}}, gt: 4'b0000};
    vecs[2] = '{mode: 2'd1, a: {8'd7, 8'd128, 8'd1, 8'd255}, b: {8'd8, 8'd128, 8'd2, 8'd1},
                xout: 32'd0, gt: 4'b0001};
    vecs[3] = '{mode: 2'd2, a: {8'd9, 8'd200, 8'd0, 8'd5}, b: {8'd9, 8'd100, 8'd1, 8'd3},
                xout: 32'd0, gt: 4'b0101};
    vecs[4] = '{mode: 2'd0, a: {8'd128, 8'd0, 8'd255, 8'd50}, b: {8'd127, 8'd1, 8'd255, 8'd50},
                xout: 32'd0, gt: 4'b1000};
    vecs[5] = '{mode: 2'd3, a: {8'd100, 8'd7, 8'd255, 8'd0}, b: {8'd90, 8'd7, 8'd0, 8'd255},
                xout: {8'd10, 8'd0, 8'd255, 8'd255}, gt: 4'b1010};
`ifdef EDGE_TRIG_ALU_SATURATE_EN
    vecs[0].xout = {8'd0, 8'd0, 8'd0, 8'd255};
    vecs[2].xout = {8'd15, 8'd255, 8'd3, 8'd255};
    vecs[3].xout = {8'd0, 8'd100, 8'd0, 8'd2};
    vecs[4].xout = {8'd255, 8'd0, 8'd0, 8'd0};
`else
    vecs[0].xout = {8'd0, 8'd0, 8'd246, 8'd44};
    vecs[2].xout = {8'd15, 8'd0, 8'd3, 8'd0};
    vecs[3].xout = {8'd0, 8'd100, 8'd255, 8'd2};
    vecs[4].xout = {8'd255, 8'd255, 8'd0, 8'd0};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = 2'd0;
    a         = '0;
    b         = '0;
    cur_x     = '0;
    cur_g     = '0;
    #12;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_xout", 64'(xout), 64'd0);
    checkOutput("reset_gt", 64'(gt), 64'd0);
    checkOutput("reset_out_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;
    step();
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] latency and CSEL wrap vector");
    latencyCheck(vecs[0]);
    drainPipe();

    $display("[TB] vector table");
    foreach (vecs[i]) applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].xout, vecs[i].gt);
    drainPipe();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    sendRandom(e1);
    sendRandom(e2);
    mode     = 2'd3;
    a        = $urandom;
    b        = $urandom;
    e3       = beatModel(mode, a, b);
    cur_x    = e3[31:0];
    cur_g    = e3[35:32];
    in_valid = 1'b1;
    #1;
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_out_valid", 64'(out_valid), 64'd1);
    held = {gt, xout};
    checkOutput("full_head_beat", 64'(held), 64'(e1));
    repeat (3) step();
    checkOutput("stall_hold", 64'({gt, xout}), 64'(held));
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    drainPipe();

    $display("[TB] stream of 8 beats");
    doReset();
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      sendRandom(r);
      if (i > 0 && out_valid) vcount++;
    end
    step();
    if (out_valid) vcount++;
    step();
    checkOutput("stream_valid_cycles", 64'(vcount), 64'd8);
    checkOutput("stream_gap_after", 64'(out_valid), 64'd0);
    checkOutput("stream_out_count", 64'(out_count), 64'd8);

    $display("[TB] reset mid-stream");
    sendRandom(r);
    sendRandom(r);
    checkOutput("inflight_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_count", 64'(out_count), 64'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (5) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checkOutput("no_stale_beat", 64'(seen), 64'd0);
    latencyCheck(vecs[1]);
    drainPipe();

    $display("[TB] counter wrap");
    doReset();
    for (int i = 0; i < 65535; i++) sendRandom(r);
    drainPipe();
    checkOutput("count_all_ones", 64'(out_count), 64'hFFFF);
    sendRandom(r);
    drainPipe();
    checkOutput("count_wrap_zero", 64'(out_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
